// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC averaging path
package adc_pkg;

  localparam int ADC_DATA_W = 12;

  typedef logic [ADC_DATA_W-1:0] adc_sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

endpackage

// File: rtl/adc_avg_filter_if.sv
// rtl/adc_avg_filter_if.sv - sample-in / average-out bundle between ADC and averaging filter
interface adc_avg_filter_if #(
  parameter int DATA_W = adc_pkg::ADC_DATA_W
);

  logic              en_i;
  logic              data_update_i;
  logic [DATA_W-1:0] data0_i;
  logic [DATA_W-1:0] data1_i;
  logic              avg_valid_o;
  logic [DATA_W-1:0] avg0_o;
  logic [DATA_W-1:0] avg1_o;
  logic              busy_o;

  // Upstream side: drives samples and enable, observes the averages.
  modport master (
    output en_i, data_update_i, data0_i, data1_i,
    input  avg_valid_o, avg0_o, avg1_o, busy_o
  );

  // Filter side.
  modport slave (
    input  en_i, data_update_i, data0_i, data1_i,
    output avg_valid_o, avg0_o, avg1_o, busy_o
  );

endinterface

// File: rtl/adc_avg_channel.sv
// rtl/adc_avg_channel.sv - one box-car accumulator with divide-by-window output register
// ADC_AVG_ROUND_EN selects round-half-up; default is truncation.
module adc_avg_channel
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] avg_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W:0]    rounded;

  assign sum = acc_q + ACC_W'(sample_i);

`ifdef ADC_AVG_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (AVG_LOG2 - 1);
  // Extra bit keeps the half-LSB bias from wrapping a full-scale sum.
  assign rounded = {1'b0, sum} + HALF;
`else
  assign rounded = {1'b0, sum};
`endif

  always_comb begin
    acc_d = acc_q;
    avg_d = avg_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      if (last_i) begin
        acc_d = '0;
        avg_d = DATA_W'(rounded >> AVG_LOG2);
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/adc_avg_filter.sv
// rtl/adc_avg_filter.sv - dual-channel box-car averager over 2^AVG_LOG2 ADC samples
// ADC_AVG_ROUND_EN (see adc_avg_channel) switches truncation to round-half-up.
module adc_avg_filter
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_avg_filter_if.slave  bus
);

  avg_state_t          state_q, state_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic accept;
  logic last;
  logic clr;

  // Enable has priority over a strobe in the same cycle, including the final one.
  assign accept = (state_q == ACCUM) && bus.en_i && bus.data_update_i;
  assign last   = accept && (cnt_q == {AVG_LOG2{1'b1}});
  assign clr    = (state_q == IDLE) || !bus.en_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en_i) state_d = ACCUM;
      end
      ACCUM: begin
        if (!bus.en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          cnt_d   = '0;
          valid_d = 1'b1;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  adc_avg_channel #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ch0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .add_i    (accept),
    .last_i   (last),
    .sample_i (bus.data0_i),
    .avg_o    (bus.avg0_o)
  );

  adc_avg_channel #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ch1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .add_i    (accept),
    .last_i   (last),
    .sample_i (bus.data1_i),
    .avg_o    (bus.avg1_o)
  );

  assign bus.avg_valid_o = valid_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// tb/tb_adc_avg_filter.sv - randomized self-checking bench for adc_avg_filter
module tb_adc_avg_filter;

  localparam int DW  = 12;
  localparam int L   = 4;
  localparam int WIN = 1 << L;
`ifdef ADC_AVG_ROUND_EN
  localparam int RND = 1 << (L - 1);
  localparam int RAMP_EXP = 8;
`else
  localparam int RND = 0;
  localparam int RAMP_EXP = 7;
`endif

  logic clk;
  logic rst_n;

  adc_avg_filter_if #(.DATA_W(DW)) bus ();

  adc_avg_filter #(
    .DATA_W   (DW),
    .AVG_LOG2 (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    nchk;
  int    nerr;
  string phase;

  // Reference model: samples accepted in the open window, and last published averages.
  int q0[$];
  int q1[$];
  int exp0;
  int exp1;
  bit armed;
  int pulses;

  task automatic check(input string tag, input int got, input int expv);
    nchk++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s/%s at %0t: got %0d expected %0d", phase, tag, $time, got, expv);
    end
  endtask

  task automatic cycle(input bit strb, input int a, input int b);
    bit acc;
    bit fire;
    int s0;
    int s1;
    bus.data_update_i = strb;
    bus.data0_i       = DW'(a);
    bus.data1_i       = DW'(b);
    @(posedge clk);
    acc   = strb && bus.en_i && armed;
    armed = bus.en_i;
    fire  = 1'b0;
    if (!bus.en_i) begin
      q0.delete();
      q1.delete();
    end else if (acc) begin
      q0.push_back(a);
      q1.push_back(b);
      if (q0.size() == WIN) begin
        s0 = 0;
        s1 = 0;
        foreach (q0[i]) s0 += q0[i];
        foreach (q1[i]) s1 += q1[i];
        exp0 = (s0 + RND) / WIN;
        exp1 = (s1 + RND) / WIN;
        q0.delete();
        q1.delete();
        fire = 1'b1;
      end
    end
    #1;
    bus.data_update_i = 1'b0;
    if (bus.avg_valid_o) pulses++;
    check("valid", int'(bus.avg_valid_o), int'(fire));
    check("avg0", int'(bus.avg0_o), exp0);
    check("avg1", int'(bus.avg1_o), exp1);
    check("busy", int'(bus.busy_o), int'(q0.size() != 0));
  endtask

  task automatic window(input int a, input int b);
    for (int i = 0; i < WIN; i++) cycle(1'b1, a, b);
  endtask

  task automatic check_zero_outputs();
    check("rst_valid", int'(bus.avg_valid_o), 0);
    check("rst_avg0", int'(bus.avg0_o), 0);
    check("rst_avg1", int'(bus.avg1_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    exp0 = 0;
    exp1 = 0;
    armed = 1'b0;
    pulses = 0;
    phase = "reset";
    rst_n = 1'b0;
    bus.en_i = 1'b0;
    bus.data_update_i = 1'b0;
    bus.data0_i = '0;
    bus.data1_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    bus.en_i = 1'b1;
    cycle(1'b0, 0, 0);
    cycle(1'b0, 0, 0);

    phase = "const";
    window(1000, 2000);
    check("const_avg0", int'(bus.avg0_o), 1000);
    check("const_avg1", int'(bus.avg1_o), 2000);
    cycle(1'b0, 0, 0);
    check("const_pulse_1cyc", int'(bus.avg_valid_o), 0);

    phase = "ramp";
    for (int i = 0; i < WIN; i++) cycle(1'b1, i, WIN - 1 - i);
    check("ramp_avg0", int'(bus.avg0_o), RAMP_EXP);

    phase = "fullscale";
    window(4095, 4095);
    check("fs_avg0", int'(bus.avg0_o), 4095);
    check("fs_avg1", int'(bus.avg1_o), 4095);
    window(0, 0);
    check("zero_avg0", int'(bus.avg0_o), 0);
    check("zero_avg1", int'(bus.avg1_o), 0);

    phase = "b2b";
    window(100, 100);
    check("b2b_first", int'(bus.avg0_o), 100);
    window(300, 300);
    check("b2b_second", int'(bus.avg0_o), 300);

    phase = "abort";
    for (int i = 0; i < 5; i++) cycle(1'b1, 500, 500);
    bus.en_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0);
    bus.en_i = 1'b1;
    cycle(1'b0, 0, 0);
    check("abort_hold", int'(bus.avg0_o), 300);
    window(200, 200);
    check("abort_next", int'(bus.avg0_o), 200);

    phase = "en_prio";
    for (int i = 0; i < WIN - 1; i++) cycle(1'b1, 700, 700);
    bus.en_i = 1'b0;
    cycle(1'b1, 700, 700);
    bus.en_i = 1'b1;
    cycle(1'b0, 0, 0);
    check("en_prio_hold", int'(bus.avg0_o), 200);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) bus.en_i = ~bus.en_i;
      if (i == 399) bus.en_i = 1'b1;
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    end
    cycle(1'b0, 0, 0);

    phase = "async_rst";
    for (int i = 0; i < 10; i++) cycle(1'b1, 777, 777);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs();
    q0.delete();
    q1.delete();
    exp0 = 0;
    exp1 = 0;
    armed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 0, 0);
    window(50, 50);
    check("post_rst_avg0", int'(bus.avg0_o), 50);
    check("post_rst_avg1", int'(bus.avg1_o), 50);
    check("pulse_seen", int'(pulses >= 9), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
Name: adc_avg_filter

Overview:
- Sits directly downstream of the dual-channel SPI ADC interface.
- Consumes its 12-bit channel-0/channel-1 samples and new-data strobe, and box-car averages 2^AVG_LOG2 consecutive samples per channel.
- Emits one averaged pair per window, with a single-cycle valid strobe, to the multimeter scaling/display path.
- Reduces noise and update rate of the displayed reading.

Parameters:
- DATA_W, 12, sample width per channel (matches ADC output).
- AVG_LOG2, 4, log2 of samples per window (legal range 1..8; default 16 samples).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_i  input  1  enable; low = hold outputs, discard partial window
- data_update_i  input  1  one-cycle strobe: data0_i/data1_i valid this cycle
- data0_i  input  DATA_W  ADC channel 0 sample
- data1_i  input  DATA_W  ADC channel 1 sample
- avg_valid_o  output  1  one-cycle strobe: new averages on avg0_o/avg1_o
- avg0_o  output  DATA_W  averaged channel 0, registered, held between strobes
- avg1_o  output  DATA_W  averaged channel 1, registered, held between strobes
- busy_o  output  1  high while a window is partially accumulated (cnt != 0)

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: avg_valid_o=0, avg0_o=0, avg1_o=0, busy_o=0, accumulators=0, sample counter=0, state=IDLE.
- Accumulators: ACC_W = DATA_W+AVG_LOG2 bits, unsigned. Overflow is impossible by construction: max sum = 4095*16 = 65520 < 2^16.
- Counter: AVG_LOG2 bits, counts accepted strobes in the current window.
- FSM state IDLE:
  - Entered on reset or en_i=0.
  - Accumulators and counter are cleared every cycle.
  - Strobes are ignored; outputs hold their last value.
  - Go to ACCUM when en_i=1.
- FSM state ACCUM, on data_update_i=1:
  - acc0 += data0_i; acc1 += data1_i; cnt++.
  - If cnt == 2^AVG_LOG2-1 (last sample of the window):
    - avg0_o <= (acc0+data0_i) >> AVG_LOG2, and likewise avg1_o (truncating).
    - avg_valid_o <= 1 for exactly one cycle.
    - acc and cnt <= 0 in the same edge.
- Latency: avg_valid_o and the new averages are visible 1 clk after the final strobe.
- Back-to-back strobes on consecutive cycles are all accepted. No sample is lost at a window boundary: the strobe following the final one is sample 0 of the next window.
- en_i falling mid-window: partial window is discarded (IDLE clears it), no valid pulse, outputs keep the previous average.
- en_i=0 in the same cycle as the final strobe: en_i has priority; the strobe is dropped and no valid pulse is issued.
- Reset asserted mid-window: all state clears immediately (asynchronous). The first window after release starts from cnt=0.
- busy_o = (cnt != 0), registered.

Optional Feature:
- Macro: ADC_AVG_ROUND_EN.
- Defined: round-half-up, avg = (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2. Sum width is ACC_W+1 internally. The result never exceeds 2^DATA_W-1 (e.g. (65520+8)>>4 = 4095), so no saturation is needed.
- Undefined: plain truncation, as in Behaviour.

Decomposition:
- Shared package adc_pkg:
  - ADC_DATA_W = 12.
  - typedef logic [ADC_DATA_W-1:0] adc_sample_t.
  - typedef enum logic {IDLE, ACCUM} avg_state_t.
- Sub-module adc_avg_channel:
  - One accumulator plus divide/round.
  - Instantiated twice; count and FSM are shared in the top.

Test Plan:
- Constant input: en_i=1, 16 strobes with data0=1000, data1=2000 -> avg0_o=1000, avg1_o=2000; avg_valid_o high exactly 1 clk after the 16th strobe, for 1 cycle.
- Ramp: data0 = 0..15 over 16 strobes -> avg0_o=7 (truncation); with ADC_AVG_ROUND_EN defined, avg0_o=8.
- Full-scale: 16 strobes of 4095 on both channels -> 4095/4095 with no wrap, in both macro variants. The next window with all zeros -> 0/0.
- Back-to-back: 32 strobes on consecutive cycles, data0=100 then 300 (16 each) -> two valid pulses 16 clk apart, values 100 then 300; busy_o low only after each boundary.
- Abort: 5 strobes of 500, en_i=0 for 3 clk, re-enable, then 16 strobes of 200 -> no pulse from the aborted window; next pulse gives 200 and the previous output is held meanwhile.
- Async reset: assert rst_n=0 after 10 strobes, between clock edges -> all outputs 0 immediately. After release, 16 strobes of 50 -> avg0_o=50.
